fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 14-bit mid-range core. Drives the program-ROM address, registers the returned 14-bit word into the instruction register (IR), and owns the 11-bit program counter (PC) and the 8-level hardware return stack. It resolves GOTO, CALL, RETURN, RETLW and RETFIE itself. It also accepts skip, computed-goto (PCL write) and stall requests from the execute stage.

## Interface
- STACK_DEPTH, 8, return-stack entries; must be a power of two.
- NOP_WORD, 14'h0000, word loaded into IR on a flush.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Rom_addr_out  out  11  program-ROM address; equals PC.
- Rom_data_in  in  14  ROM word. The ROM is combinational, so the word is valid in the same cycle as the address.
- stall  in  1  hold PC, IR, ir_pc and the stack.
- skip  in  1  execute requests that the next instruction be squashed.
- pcl_wr  in  1  execute wrote PCL (computed goto).
- pcl_data  in  8  value written to PCL.
- pclath  in  3  PCLATH[2:0], the upper PC bits for a computed goto.
- ir_out  out  14  instruction register, consumed by decode/execute.
- ir_pc  out  11  address of the word currently in IR.
- stack_ovf  out  1  sticky flag: a push occurred with the stack full.
- stack_unf  out  1  sticky flag: a pop occurred with the stack empty.

## Operation
- Reset values: PC=0, ir_out=NOP_WORD, ir_pc=0, stack pointer=0, stack count=0, stack_ovf=0, stack_unf=0. Stack contents are don't-care.
- Reset is asynchronous and may assert mid-operation. It overrides everything, including an in-flight branch or stall.
- Decode of ir_out, which is done inside this block:
  - GOTO: ir[13:11]=3'b101.
  - CALL: ir[13:11]=3'b100.
  - RETURN: 14'h0008.
  - RETFIE: 14'h0009.
  - RETLW: ir[13:10]=4'b1101.
- Per-cycle priority, with the first match winning:
  1. stall: all state holds.
  2. GOTO: PC←ir[10:0]; IR←NOP_WORD.
  3. CALL: push PC; PC←ir[10:0]; IR←NOP_WORD.
  4. RETURN, RETLW or RETFIE: PC←pop; IR←NOP_WORD.
  5. pcl_wr: PC←{pclath, pcl_data}; IR←NOP_WORD.
  6. skip: IR←NOP_WORD; PC←PC+1.
  7. Normal: IR←Rom_data_in; ir_pc←PC; PC←PC+1.
- The pushed return address is the current PC, which is always ir_pc+1.
- ir_pc always tracks the address of the word loaded into IR. On a flush (cases 2–6), ir_pc←PC, the address of the discarded word.
- PC increment is 11-bit modulo: 0x7FF+1 wraps to 0x000. There is no flag.
- Stack is a circular buffer indexed by a log2(STACK_DEPTH)-bit pointer.
  - Push: write entry[sp]; sp←sp+1.
  - Pop: sp←sp−1; read entry[sp].
- Stack count saturates at 0 and STACK_DEPTH.
  - Push at count=STACK_DEPTH: overwrites the oldest entry and sets stack_ovf.
  - Pop at count=0: returns the wrapped entry and sets stack_unf.
- stack_ovf and stack_unf clear only on reset.
- skip or pcl_wr arriving while IR holds a branch is ignored; the branch wins.

## Timing
- Fetch latency: an address presented in cycle n appears on ir_out after edge n.
- Every taken control transfer (GOTO, CALL, return, PCL write) costs exactly one bubble cycle with ir_out=NOP_WORD. A skip costs one bubble.
- First fetched word reaches ir_out one edge after rst_n deasserts.
- A stall for k cycles delays the stream by exactly k cycles. There is no loss or duplication.
- The block contains no combinational path from inputs to Rom_addr_out. Rom_addr_out is purely registered PC.

## Test plan
- Reset then free-run with ROM word 0x000=14'h01A5 and word 0x001=14'h01A4:
  - After the first edge: ir_out=01A5, ir_pc=0, Rom_addr_out=1.
  - After the next edge: ir_out=01A4.
- GOTO: IR=14'h2810 with ir_pc=0x11.
  - Next edge: PC=0x010 and ir_out=0000.
  - Following edge: ir_out equals ROM[0x010] and ir_pc=0x010.
- CALL then RETURN: IR=14'h20C0 at ir_pc=0x005.
  - After the CALL: PC=0x0C0 and stack holds 0x006.
  - A later RETURN (14'h0008) gives PC=0x006 with one bubble.
- Stack overflow: nine nested CALLs with no returns. After the ninth push stack_ovf=1. The first of nine RETURNs yields the ninth return address.
- Skip and computed goto:
  - skip=1 while ir_out=14'h0BA2 at ir_pc=0x010: ir_out=0000 and PC=0x012.
  - pcl_wr=1 with pclath=3'b010 and pcl_data=8'h34: PC=0x234 with one bubble.
- Stall and reset:
  - stall=1 for 3 cycles holds PC, ir_out and ir_pc unchanged.
  - rst_n low during a CALL bubble: PC=0, ir_out=0000 and flags=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC, IR and the hardware return stack; resolves GOTO/CALL/returns in-block.
// Latency: ROM word at PC lands in IR one edge later; every taken transfer or skip costs one NOP bubble.
// Backpressure: stall freezes PC, IR, ir_pc and the stack; Rom_addr_out is the registered PC only.
module fetch_unit #(
    parameter int          STACK_DEPTH = 8,
    parameter logic [13:0] NOP_WORD    = 14'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] Rom_addr_out,
    input  logic [13:0] Rom_data_in,
    input  logic        stall,
    input  logic        skip,
    input  logic        pcl_wr,
    input  logic [7:0]  pcl_data,
    input  logic [2:0]  pclath,
    output logic [13:0] ir_out,
    output logic [10:0] ir_pc,
    output logic        stack_ovf,
    output logic        stack_unf
);
    localparam int SPW = $clog2(STACK_DEPTH);
    localparam int CW  = $clog2(STACK_DEPTH + 1);

    logic [10:0]    pc;
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_dec;
    logic [CW-1:0]  cnt;
    logic [10:0]    stack_mem [STACK_DEPTH];

    logic is_goto;
    logic is_call;
    logic is_ret;
    logic do_push;
    logic stack_full;
    logic stack_empty;

    assign is_goto     = (ir_out[13:11] == 3'b101);
    assign is_call     = (ir_out[13:11] == 3'b100);
    assign is_ret      = (ir_out == 14'h0008) || (ir_out == 14'h0009) || (ir_out[13:10] == 4'b1101);
    assign do_push     = !stall && is_call;
    assign sp_dec      = sp - SPW'(1);
    assign stack_full  = (cnt == CW'(STACK_DEPTH));
    assign stack_empty = (cnt == '0);

    assign Rom_addr_out = pc;

    // Stack contents are never reset; only the pointer and count are.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[sp] <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            ir_out    <= NOP_WORD;
            ir_pc     <= '0;
            sp        <= '0;
            cnt       <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (!stall) begin
            if (is_goto) begin
                pc     <= ir_out[10:0];
                ir_out <= NOP_WORD;
                ir_pc  <= pc;
            end else if (is_call) begin
                // PC already points past the CALL, so it is the return address.
                pc     <= ir_out[10:0];
                ir_out <= NOP_WORD;
                ir_pc  <= pc;
                sp     <= sp + SPW'(1);
                if (stack_full) begin
                    stack_ovf <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (is_ret) begin
                pc     <= stack_mem[sp_dec];
                ir_out <= NOP_WORD;
                ir_pc  <= pc;
                sp     <= sp_dec;
                if (stack_empty) begin
                    stack_unf <= 1'b1;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end else if (pcl_wr) begin
                pc     <= {pclath, pcl_data};
                ir_out <= NOP_WORD;
                ir_pc  <= pc;
            end else if (skip) begin
                pc     <= pc + 11'd1;
                ir_out <= NOP_WORD;
                ir_pc  <= pc;
            end else begin
                pc     <= pc + 11'd1;
                ir_out <= Rom_data_in;
                ir_pc  <= pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-built stack/reset sequences, then random
// ROM and control traffic, all compared cycle by cycle against a behavioural model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] rom_addr;
    logic [13:0] rom_data;
    logic        stall = 1'b0;
    logic        skip = 1'b0;
    logic        pcl_wr = 1'b0;
    logic [7:0]  pcl_data = 8'h00;
    logic [2:0]  pclath = 3'h0;
    logic [13:0] ir_out;
    logic [10:0] ir_pc;
    logic        stack_ovf;
    logic        stack_unf;

    logic [13:0] rom [2048];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    fetch_unit #(.STACK_DEPTH(8), .NOP_WORD(14'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rom_addr_out(rom_addr),
        .Rom_data_in (rom_data),
        .stall       (stall),
        .skip        (skip),
        .pcl_wr      (pcl_wr),
        .pcl_data    (pcl_data),
        .pclath      (pclath),
        .ir_out      (ir_out),
        .ir_pc       (ir_pc),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: architectural state plus an 8-entry circular return stack.
    logic [10:0] m_pc;
    logic [10:0] m_irpc;
    logic [13:0] m_ir;
    logic [10:0] m_stk [8];
    int          m_sp;
    int          m_cnt;
    bit          m_ovf;
    bit          m_unf;

    function automatic int kind(input logic [13:0] w);
        if (w[13:11] == 3'b101) return 1;
        if (w[13:11] == 3'b100) return 2;
        if (w == 14'h0008 || w == 14'h0009 || w[13:10] == 4'b1101) return 3;
        return 0;
    endfunction

    task automatic m_reset();
        m_pc = '0; m_ir = 14'h0000; m_irpc = '0;
        m_sp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic m_step(input bit st, input bit sk, input bit pw,
                          input logic [7:0] pd, input logic [2:0] pl);
        int          k;
        logic [10:0] npc;
        if (st) return;
        k = kind(m_ir);
        if (k == 1) begin
            npc = m_ir[10:0];
        end else if (k == 2) begin
            m_stk[m_sp] = m_pc;
            m_sp = (m_sp + 1) % 8;
            if (m_cnt == 8) m_ovf = 1; else m_cnt++;
            npc = m_ir[10:0];
        end else if (k == 3) begin
            m_sp = (m_sp + 7) % 8;
            npc = m_stk[m_sp];
            if (m_cnt == 0) m_unf = 1; else m_cnt--;
        end else if (pw) begin
            npc = {pl, pd};
        end else begin
            npc = m_pc + 11'd1;
        end
        if (k != 0 || pw || sk) m_ir = 14'h0000;
        else m_ir = rom[m_pc];
        m_irpc = m_pc;
        m_pc = npc;
    endtask

    task automatic cmp_model(input string tag);
        check({tag, "_pc"},    rom_addr,  m_pc);
        check({tag, "_ir"},    ir_out,    m_ir);
        check({tag, "_irpc"},  ir_pc,     m_irpc);
        check({tag, "_ovf"},   stack_ovf, m_ovf);
        check({tag, "_unf"},   stack_unf, m_unf);
    endtask

    task automatic tick(input bit st, input bit sk, input bit pw,
                        input logic [7:0] pd, input logic [2:0] pl, input string tag);
        stall = st; skip = sk; pcl_wr = pw; pcl_data = pd; pclath = pl;
        @(posedge clk);
        m_step(st, sk, pw, pd, pl);
        #1;
        cmp_model(tag);
    endtask

    typedef struct {
        bit          st;
        bit          sk;
        bit          pw;
        logic [7:0]  pd;
        logic [2:0]  pl;
        logic [10:0] pc;
        logic [13:0] ir;
        logic [10:0] irpc;
    } vec_t;

    vec_t tbl [21];

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 14'(14'h1000 + i);
        rom[11'h000] = 14'h01A5;
        rom[11'h001] = 14'h01A4;
        rom[11'h002] = 14'h2811;
        rom[11'h011] = 14'h2810;
        rom[11'h010] = 14'h0BA2;
        rom[11'h012] = 14'h2805;
        rom[11'h005] = 14'h20C0;
        rom[11'h0C0] = 14'h0008;
        for (int k = 0; k < 9; k++) begin
            rom[11'(11'h400 + 16 * k)] = 14'(14'h2000 + 11'h400 + 16 * (k + 1));
            rom[11'(11'h401 + 16 * k)] = 14'h0008;
        end
        rom[11'h490] = 14'h0008;

        //          st sk pw  pd     pl    pc      ir        ir_pc
        tbl[0]  = '{0, 0, 0, 8'h00, 3'h0, 11'h001, 14'h01A5, 11'h000};
        tbl[1]  = '{0, 0, 0, 8'h00, 3'h0, 11'h002, 14'h01A4, 11'h001};
        tbl[2]  = '{0, 0, 0, 8'h00, 3'h0, 11'h003, 14'h2811, 11'h002};
        tbl[3]  = '{0, 0, 0, 8'h00, 3'h0, 11'h011, 14'h0000, 11'h003};
        tbl[4]  = '{0, 0, 0, 8'h00, 3'h0, 11'h012, 14'h2810, 11'h011};
        tbl[5]  = '{0, 0, 0, 8'h00, 3'h0, 11'h010, 14'h0000, 11'h012};
        tbl[6]  = '{0, 0, 0, 8'h00, 3'h0, 11'h011, 14'h0BA2, 11'h010};
        tbl[7]  = '{0, 1, 0, 8'h00, 3'h0, 11'h012, 14'h0000, 11'h011};
        tbl[8]  = '{0, 0, 0, 8'h00, 3'h0, 11'h013, 14'h2805, 11'h012};
        tbl[9]  = '{0, 1, 1, 8'hFF, 3'h7, 11'h005, 14'h0000, 11'h013};
        tbl[10] = '{0, 0, 0, 8'h00, 3'h0, 11'h006, 14'h20C0, 11'h005};
        tbl[11] = '{0, 0, 0, 8'h00, 3'h0, 11'h0C0, 14'h0000, 11'h006};
        tbl[12] = '{0, 0, 0, 8'h00, 3'h0, 11'h0C1, 14'h0008, 11'h0C0};
        tbl[13] = '{0, 0, 0, 8'h00, 3'h0, 11'h006, 14'h0000, 11'h0C1};
        tbl[14] = '{0, 0, 0, 8'h00, 3'h0, 11'h007, 14'h1006, 11'h006};
        tbl[15] = '{0, 0, 1, 8'h34, 3'h2, 11'h234, 14'h0000, 11'h007};
        tbl[16] = '{0, 0, 0, 8'h00, 3'h0, 11'h235, 14'h1234, 11'h234};
        tbl[17] = '{1, 1, 1, 8'h55, 3'h1, 11'h235, 14'h1234, 11'h234};
        tbl[18] = '{1, 0, 0, 8'h00, 3'h0, 11'h235, 14'h1234, 11'h234};
        tbl[19] = '{1, 0, 0, 8'h00, 3'h0, 11'h235, 14'h1234, 11'h234};
        tbl[20] = '{0, 0, 0, 8'h00, 3'h0, 11'h236, 14'h1235, 11'h235};

        #1 rst_n = 1'b0;
        m_reset();
        #11;
        check("rst_pc", rom_addr, 11'h000);
        check("rst_ir", ir_out, 14'h0000);
        check("rst_irpc", ir_pc, 11'h000);
        check("rst_ovf", stack_ovf, 1'b0);
        check("rst_unf", stack_unf, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            tick(tbl[i].st, tbl[i].sk, tbl[i].pw, tbl[i].pd, tbl[i].pl, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_tpc", i), rom_addr, tbl[i].pc);
            check($sformatf("vec%0d_tir", i), ir_out, tbl[i].ir);
            check($sformatf("vec%0d_tirpc", i), ir_pc, tbl[i].irpc);
        end

        // Nine nested CALLs from 0x400, then returns until the stack underflows.
        tick(0, 0, 1, 8'h00, 3'h4, "ovf_jmp");
        for (int i = 0; i < 16; i++) tick(0, 0, 0, 8'h00, 3'h0, "ovf_call");
        check("ovf_before_ninth", stack_ovf, 1'b0);
        check("pc_before_ninth", rom_addr, 11'h480);
        tick(0, 0, 0, 8'h00, 3'h0, "ovf_call9a");
        tick(0, 0, 0, 8'h00, 3'h0, "ovf_call9b");
        check("ovf_after_ninth", stack_ovf, 1'b1);
        check("pc_after_ninth", rom_addr, 11'h490);
        tick(0, 0, 0, 8'h00, 3'h0, "ret1a");
        tick(0, 0, 0, 8'h00, 3'h0, "ret1b");
        check("first_ret_addr", rom_addr, 11'h481);
        check("first_ret_bubble", ir_out, 14'h0000);
        for (int i = 0; i < 16; i++) tick(0, 0, 0, 8'h00, 3'h0, "ret_chain");
        check("unf_set", stack_unf, 1'b1);
        check("unf_wrapped_addr", rom_addr, 11'h481);

        // Asynchronous reset landing in a CALL bubble.
        tick(0, 0, 1, 8'h00, 3'h4, "rc_jmp");
        tick(0, 0, 0, 8'h00, 3'h0, "rc_load");
        tick(0, 0, 0, 8'h00, 3'h0, "rc_bubble");
        check("rc_bubble_pc", rom_addr, 11'h410);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc", rom_addr, 11'h000);
        check("arst_ir", ir_out, 14'h0000);
        check("arst_irpc", ir_pc, 11'h000);
        check("arst_ovf", stack_ovf, 1'b0);
        check("arst_unf", stack_unf, 1'b0);
        m_reset();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick(0, 0, 0, 8'h00, 3'h0, "post_rst");
        check("post_rst_ir", ir_out, 14'h01A5);

        // Random program and random control traffic.
        for (int i = 0; i < 2048; i++) begin
            case ($urandom_range(0, 15))
                0:       rom[i] = 14'(14'h2800 | $urandom_range(0, 2047));
                1:       rom[i] = 14'(14'h2000 | $urandom_range(0, 2047));
                2:       rom[i] = 14'h0008;
                3:       rom[i] = 14'h0009;
                4:       rom[i] = 14'(14'h3400 | $urandom_range(0, 255));
                default: rom[i] = 14'($urandom_range(0, 16383));
            endcase
        end
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 8, 8'($urandom_range(0, 255)),
                 3'($urandom_range(0, 7)), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
